// File: rtl/bv_lookup_sched.sv
// Port scheduler for the three single-port BV banks feeding the 3-input AND stage.
// Arbitrates lookups against table writes, clears tables, and times the AND enable.
module bv_lookup_sched #(
   parameter int ADDR_W     = 9,
   parameter int BV_W       = 36,
   parameter int RAM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              lk_valid,
   output logic              lk_ready,
   input  logic [ADDR_W-1:0] lk_key_1,
   input  logic [ADDR_W-1:0] lk_key_2,
   input  logic [ADDR_W-1:0] lk_key_3,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [1:0]        cfg_sel,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [BV_W-1:0]   cfg_data,
   input  logic              init_req,
   output logic              init_busy,
   output logic [ADDR_W-1:0] ram_addr_1,
   output logic [ADDR_W-1:0] ram_addr_2,
   output logic [ADDR_W-1:0] ram_addr_3,
   output logic              ram_we_1,
   output logic              ram_we_2,
   output logic              ram_we_3,
   output logic [BV_W-1:0]   ram_wdata,
   output logic              and_enable,
   output logic [2:0]        inflight
);

   localparam logic [1:0] S_CLEAR = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;

   logic [1:0]         state_q, state_d;
   logic [ADDR_W-1:0]  clr_q, clr_d;
   logic [SW-1:0]      starve_q, starve_d;
   logic [RAM_LAT-1:0] en_q, en_d;
   logic [2:0]         infl_q, infl_d;
   logic               lk_rdy_q, lk_rdy_d;
   logic               cfg_rdy_q, cfg_rdy_d;
   logic               busy_q, busy_d;
   logic               and_en_q, and_en_d;
   logic [2:0]         we_q, we_d;
   logic [ADDR_W-1:0]  a1_q, a1_d;
   logic [ADDR_W-1:0]  a2_q, a2_d;
   logic [ADDR_W-1:0]  a3_q, a3_d;
   logic [BV_W-1:0]    wd_q, wd_d;
   logic               lk_gnt, cfg_gnt;

   always_comb begin
      state_d  = state_q;
      clr_d    = clr_q;
      we_d     = 3'b000;
      a1_d     = a1_q;
      a2_d     = a2_q;
      a3_d     = a3_q;
      wd_d     = wd_q;
      lk_gnt   = 1'b0;
      cfg_gnt  = 1'b0;

      unique case (state_q)
         S_CLEAR: begin
            we_d  = 3'b111;
            a1_d  = clr_q;
            a2_d  = clr_q;
            a3_d  = clr_q;
            wd_d  = '0;
            clr_d = clr_q + ADDR_W'(1);
            if (clr_q == ADDR_LAST) state_d = S_RUN;
         end
         S_RUN: begin
            // init_req wins over any grant pending this cycle
            if (init_req) begin
               state_d = S_DRAIN;
            end else if (cfg_valid &&
                         (!lk_valid || starve_q == STARVE_LIM)) begin
               cfg_gnt = 1'b1;
            end else if (lk_valid) begin
               lk_gnt = 1'b1;
            end
         end
         S_DRAIN: begin
            if (infl_q == 3'd0) begin
               state_d = S_CLEAR;
               clr_d   = '0;
            end
         end
         default: state_d = S_CLEAR;
      endcase

      if (lk_gnt) begin
         a1_d = lk_key_1;
         a2_d = lk_key_2;
         a3_d = lk_key_3;
      end

      if (cfg_gnt) begin
         wd_d = cfg_data;
         case (cfg_sel)
            2'd1: begin we_d[0] = 1'b1; a1_d = cfg_addr; end
            2'd2: begin we_d[1] = 1'b1; a2_d = cfg_addr; end
            2'd3: begin we_d[2] = 1'b1; a3_d = cfg_addr; end
            default: ;
         endcase
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (cfg_gnt || !cfg_valid) begin
         starve_d = '0;
      end else if (lk_gnt && starve_q != STARVE_LIM) begin
         starve_d = starve_q + SW'(1);
      end
   end

   // en_q[0] lines up with the grant cycle; the tail drives the AND stage
   assign en_d      = RAM_LAT'({en_q, lk_gnt});
   assign and_en_d  = en_q[RAM_LAT-1];
   assign infl_d    = infl_q + 3'(lk_gnt) - 3'(and_en_d);
   assign lk_rdy_d  = lk_gnt;
   assign cfg_rdy_d = cfg_gnt;
   assign busy_d    = (state_q != S_RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_CLEAR;
         clr_q     <= '0;
         starve_q  <= '0;
         en_q      <= '0;
         infl_q    <= 3'd0;
         lk_rdy_q  <= 1'b0;
         cfg_rdy_q <= 1'b0;
         busy_q    <= 1'b1;
         and_en_q  <= 1'b0;
         we_q      <= 3'b000;
         a1_q      <= '0;
         a2_q      <= '0;
         a3_q      <= '0;
         wd_q      <= '0;
      end else begin
         state_q   <= state_d;
         clr_q     <= clr_d;
         starve_q  <= starve_d;
         en_q      <= en_d;
         infl_q    <= infl_d;
         lk_rdy_q  <= lk_rdy_d;
         cfg_rdy_q <= cfg_rdy_d;
         busy_q    <= busy_d;
         and_en_q  <= and_en_d;
         we_q      <= we_d;
         a1_q      <= a1_d;
         a2_q      <= a2_d;
         a3_q      <= a3_d;
         wd_q      <= wd_d;
      end
   end

   assign lk_ready   = lk_rdy_q;
   assign cfg_ready  = cfg_rdy_q;
   assign init_busy  = busy_q;
   assign ram_addr_1 = a1_q;
   assign ram_addr_2 = a2_q;
   assign ram_addr_3 = a3_q;
   assign ram_we_1   = we_q[0];
   assign ram_we_2   = we_q[1];
   assign ram_we_3   = we_q[2];
   assign ram_wdata  = wd_q;
   assign and_enable = and_en_q;
   assign inflight   = infl_q;

endmodule

// File: tb/tb_bv_lookup_sched.sv
// Directed bench for bv_lookup_sched: clear sweep, writes, lookups,
// starvation limit, drain/re-clear and mid-stream reset.
module tb_bv_lookup_sched;

   localparam int AW = 9;
   localparam int BW = 36;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          lk_valid = 1'b0;
   logic          lk_ready;
   logic [AW-1:0] lk_key_1 = '0;
   logic [AW-1:0] lk_key_2 = '0;
   logic [AW-1:0] lk_key_3 = '0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [1:0]    cfg_sel = 2'd0;
   logic [AW-1:0] cfg_addr = '0;
   logic [BW-1:0] cfg_data = '0;
   logic          init_req = 1'b0;
   logic          init_busy;
   logic [AW-1:0] ram_addr_1, ram_addr_2, ram_addr_3;
   logic          ram_we_1, ram_we_2, ram_we_3;
   logic [BW-1:0] ram_wdata;
   logic          and_enable;
   logic [2:0]    inflight;
   logic [2:0]    we;

   int n_checks = 0;
   int n_fail   = 0;

   assign we = {ram_we_3, ram_we_2, ram_we_1};

   always #5 clk = ~clk;

   bv_lookup_sched #(
      .ADDR_W(AW), .BV_W(BW), .RAM_LAT(2), .STARVE_MAX(4)
   ) dut (
      .clk(clk), .reset(reset),
      .lk_valid(lk_valid), .lk_ready(lk_ready),
      .lk_key_1(lk_key_1), .lk_key_2(lk_key_2), .lk_key_3(lk_key_3),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .init_req(init_req), .init_busy(init_busy),
      .ram_addr_1(ram_addr_1), .ram_addr_2(ram_addr_2),
      .ram_addr_3(ram_addr_3),
      .ram_we_1(ram_we_1), .ram_we_2(ram_we_2), .ram_we_3(ram_we_3),
      .ram_wdata(ram_wdata), .and_enable(and_enable),
      .inflight(inflight)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Walks 512 cycles of clear writes, counting cycles that deviate.
   task automatic sweep_clear(output int bad);
      bad = 0;
      for (int i = 0; i < 512; i++) begin
         tick();
         if (we !== 3'b111 || ram_addr_1 !== AW'(i) ||
             ram_addr_2 !== AW'(i) || ram_addr_3 !== AW'(i) ||
             ram_wdata !== '0 || init_busy !== 1'b1 ||
             and_enable !== 1'b0 || lk_ready !== 1'b0 ||
             cfg_ready !== 1'b0)
            bad++;
         init_req = (i == 100);
      end
      init_req = 1'b0;
   endtask

   task automatic test_reset();
      int bad;
      reset = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({lk_ready, cfg_ready, we, and_enable} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctl got %b want 000000",
                  {lk_ready, cfg_ready, we, and_enable});
      end
      n_checks++;
      if (init_busy !== 1'b1 || inflight !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_busy got busy=%b infl=%0d want 1/0",
                  init_busy, inflight);
      end
      n_checks++;
      if (ram_addr_1 !== '0 || ram_wdata !== '0) begin
         n_fail++;
         $display("FAIL reset_data got a=%0d wd=%h want 0/0",
                  ram_addr_1, ram_wdata);
      end
      reset = 1'b0;
      sweep_clear(bad);
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL reset_sweep got %0d bad cycles want 0", bad);
      end
      tick();
      n_checks++;
      if (init_busy !== 1'b0 || we !== 3'b000) begin
         n_fail++;
         $display("FAIL clear_done got busy=%b we=%b want 0/000",
                  init_busy, we);
      end
   endtask

   task automatic test_cfg_write_lookup();
      cfg_valid = 1'b1;
      cfg_sel   = 2'd2;
      cfg_addr  = 9'd5;
      cfg_data  = 36'h0_F0F0_F0F0;
      tick();
      cfg_valid = 1'b0;
      n_checks++;
      if (cfg_ready !== 1'b1 || we !== 3'b010 || ram_addr_2 !== 9'd5 ||
          ram_wdata !== 36'h0_F0F0_F0F0) begin
         n_fail++;
         $display("FAIL cfg_wr got rdy=%b we=%b a2=%0d wd=%h want 1/010/5/0f0f0f0f0",
                  cfg_ready, we, ram_addr_2, ram_wdata);
      end
      tick();
      n_checks++;
      if (cfg_ready !== 1'b0 || we !== 3'b000) begin
         n_fail++;
         $display("FAIL cfg_wr_end got rdy=%b we=%b want 0/000",
                  cfg_ready, we);
      end
      lk_valid = 1'b1;
      lk_key_1 = 9'd5;
      lk_key_2 = 9'd5;
      lk_key_3 = 9'd5;
      tick();
      lk_valid = 1'b0;
      n_checks++;
      if (lk_ready !== 1'b1 || we !== 3'b000 || ram_addr_1 !== 9'd5 ||
          ram_addr_3 !== 9'd5 || inflight !== 3'd1 ||
          and_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL lk_grant got rdy=%b we=%b a1=%0d infl=%0d en=%b want 1/000/5/1/0",
                  lk_ready, we, ram_addr_1, inflight, and_enable);
      end
      tick();
      n_checks++;
      if (and_enable !== 1'b0 || inflight !== 3'd1) begin
         n_fail++;
         $display("FAIL lk_lat1 got en=%b infl=%0d want 0/1",
                  and_enable, inflight);
      end
      tick();
      n_checks++;
      if (and_enable !== 1'b1 || inflight !== 3'd0) begin
         n_fail++;
         $display("FAIL lk_lat2 got en=%b infl=%0d want 1/0",
                  and_enable, inflight);
      end
      tick();
      n_checks++;
      if (and_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL lk_pulse got en=%b want 0", and_enable);
      end
   endtask

   task automatic test_cfg_sel0();
      cfg_valid = 1'b1;
      cfg_sel   = 2'd0;
      cfg_addr  = 9'd3;
      cfg_data  = 36'hA_AAAA_AAAA;
      tick();
      cfg_valid = 1'b0;
      n_checks++;
      if (cfg_ready !== 1'b1 || we !== 3'b000) begin
         n_fail++;
         $display("FAIL sel0 got rdy=%b we=%b want 1/000", cfg_ready, we);
      end
      tick();
      n_checks++;
      if (cfg_ready !== 1'b0 || we !== 3'b000) begin
         n_fail++;
         $display("FAIL sel0_end got rdy=%b we=%b want 0/000",
                  cfg_ready, we);
      end
   endtask

   task automatic test_starve();
      int bad = 0;
      int nlk = 0;
      int nen = 0;
      logic exp_lk, exp_cfg, exp_en;
      lk_valid  = 1'b1;
      lk_key_1  = 9'd10;
      lk_key_2  = 9'd11;
      lk_key_3  = 9'd12;
      cfg_valid = 1'b1;
      cfg_sel   = 2'd1;
      cfg_addr  = 9'd7;
      cfg_data  = 36'h1_2345_6789;
      for (int k = 0; k < 22; k++) begin
         tick();
         exp_lk  = (k < 20) && (k % 5 != 4);
         exp_cfg = (k < 20) && (k % 5 == 4);
         exp_en  = (k >= 2) && ((k - 2) % 5 != 4);
         if (lk_ready !== exp_lk || cfg_ready !== exp_cfg ||
             and_enable !== exp_en)
            bad++;
         if (exp_cfg && (we !== 3'b001 || ram_addr_1 !== 9'd7))
            bad++;
         if (lk_ready === 1'b1) nlk++;
         if (and_enable === 1'b1) nen++;
         if (k == 19) begin
            lk_valid  = 1'b0;
            cfg_valid = 1'b0;
         end
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL starve_pattern got %0d bad cycles want 0", bad);
      end
      n_checks++;
      if (nlk !== 16) begin
         n_fail++;
         $display("FAIL starve_lookups got %0d want 16", nlk);
      end
      n_checks++;
      if (nen !== 16) begin
         n_fail++;
         $display("FAIL starve_enables got %0d want 16", nen);
      end
   endtask

   task automatic test_back_to_back();
      int bad;
      lk_valid = 1'b1;
      lk_key_1 = 9'd1; lk_key_2 = 9'd2; lk_key_3 = 9'd3;
      tick();
      lk_key_1 = 9'd4; lk_key_2 = 9'd5; lk_key_3 = 9'd6;
      tick();
      lk_key_1 = 9'd7; lk_key_2 = 9'd8; lk_key_3 = 9'd9;
      tick();
      n_checks++;
      if (lk_ready !== 1'b1 || and_enable !== 1'b1 ||
          inflight !== 3'd2) begin
         n_fail++;
         $display("FAIL b2b_g2 got rdy=%b en=%b infl=%0d want 1/1/2",
                  lk_ready, and_enable, inflight);
      end
      init_req = 1'b1;
      tick();
      init_req = 1'b0;
      n_checks++;
      if (lk_ready !== 1'b0 || and_enable !== 1'b1 ||
          inflight !== 3'd1) begin
         n_fail++;
         $display("FAIL drain_g3 got rdy=%b en=%b infl=%0d want 0/1/1",
                  lk_ready, and_enable, inflight);
      end
      tick();
      n_checks++;
      if (and_enable !== 1'b1 || inflight !== 3'd0 ||
          init_busy !== 1'b1 || lk_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_g4 got en=%b infl=%0d busy=%b rdy=%b want 1/0/1/0",
                  and_enable, inflight, init_busy, lk_ready);
      end
      tick();
      n_checks++;
      if (and_enable !== 1'b0 || we !== 3'b000 || lk_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_g5 got en=%b we=%b rdy=%b want 0/000/0",
                  and_enable, we, lk_ready);
      end
      sweep_clear(bad);
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL reclear_sweep got %0d bad cycles want 0", bad);
      end
      tick();
      lk_valid = 1'b0;
      n_checks++;
      if (lk_ready !== 1'b1 || init_busy !== 1'b0 ||
          ram_addr_2 !== 9'd8) begin
         n_fail++;
         $display("FAIL held_lookup got rdy=%b busy=%b a2=%0d want 1/0/8",
                  lk_ready, init_busy, ram_addr_2);
      end
      tick();
      tick();
      n_checks++;
      if (and_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL held_enable got %b want 1", and_enable);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int bad;
      lk_valid = 1'b1;
      lk_key_1 = 9'd20; lk_key_2 = 9'd21; lk_key_3 = 9'd22;
      tick();
      tick();
      n_checks++;
      if (inflight !== 3'd2) begin
         n_fail++;
         $display("FAIL mid_inflight got %0d want 2", inflight);
      end
      lk_valid = 1'b0;
      reset    = 1'b1;
      tick();
      reset    = 1'b0;
      n_checks++;
      if (and_enable !== 1'b0 || inflight !== 3'd0 ||
          init_busy !== 1'b1 || we !== 3'b000) begin
         n_fail++;
         $display("FAIL mid_reset got en=%b infl=%0d busy=%b we=%b want 0/0/1/000",
                  and_enable, inflight, init_busy, we);
      end
      sweep_clear(bad);
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL mid_sweep got %0d bad cycles want 0", bad);
      end
      tick();
      n_checks++;
      if (init_busy !== 1'b0 || inflight !== 3'd0) begin
         n_fail++;
         $display("FAIL mid_done got busy=%b infl=%0d want 0/0",
                  init_busy, inflight);
      end
   endtask

   initial begin
      test_reset();
      test_cfg_write_lookup();
      test_cfg_sel0();
      test_starve();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
